// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register map,
// controller state encoding and CTRL bit positions.
package irq_pkg;

  localparam int unsigned MAX_IRQ = 6;

  // Word offsets inside the 4-register window (byte address bits [3:2])
  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int unsigned CTRL_GIE       = 0;
  localparam int unsigned STAT_INSVC_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder.
module irq_prio_enc #(
  parameter int unsigned N = 6
) (
  input  logic [N-1:0] vec_i,
  output logic         valid_o,
  output logic [2:0]   id_o
);

  // Scan from the highest index down so the lowest set bit is the last writer
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec_i[N-1-i]) begin
        valid_o = 1'b1;
        id_o    = 3'(N-1-i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: 2-flop synchronisers, per-line edge/level
// pending latch, software mask, global enable, fixed lowest-index priority and
// a request/acknowledge/return handshake with the CPU.
// Optional nesting of higher-priority requests: define IRQ_CTRL_NESTED_EN.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ   = 6,
  parameter logic [5:0]  EDGE_MASK = 6'b000011
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [1:0]         addr,
  input  logic               we,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               int_req,
  output logic [2:0]         int_id,
  input  logic               int_ack,
  input  logic               eret
);

  localparam logic [NUM_IRQ-1:0] EdgeM = EDGE_MASK[NUM_IRQ-1:0];

  logic [NUM_IRQ-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] mask_q;
  logic               gie_q;
  logic [NUM_IRQ-1:0] insvc_q, insvc_d;
  irq_state_e         state_q, state_d;
  logic               int_req_q, int_req_d;
  logic [2:0]         int_id_q, int_id_d;

  logic [NUM_IRQ-1:0] elig, id_oh, top_oh, ack_clr, w1c;
  logic               win_valid, top_valid, req_elig;
  logic [2:0]         win_id, top_id;
  logic               unused_wdata;

  assign unused_wdata = ^wdata;
  assign elig         = pend_q & mask_q & {NUM_IRQ{gie_q}};

  irq_prio_enc #(.N(NUM_IRQ)) u_win (
    .vec_i   (elig),
    .valid_o (win_valid),
    .id_o    (win_id)
  );

  irq_prio_enc #(.N(NUM_IRQ)) u_top (
    .vec_i   (insvc_q),
    .valid_o (top_valid),
    .id_o    (top_id)
  );

  // One-hot forms of the requested id and the highest-priority in-service line
  always_comb begin
    id_oh  = '0;
    top_oh = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      id_oh[i]  = (int_id_q == 3'(i));
      top_oh[i] = top_valid && (top_id == 3'(i));
    end
  end

  assign req_elig = |(elig & id_oh);

  // Controller state and registered CPU-facing outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      int_req_q <= 1'b0;
      int_id_q  <= '0;
      insvc_q   <= '0;
    end else begin
      state_q   <= state_d;
      int_req_q <= int_req_d;
      int_id_q  <= int_id_d;
      insvc_q   <= insvc_d;
    end
  end

  // Next-state: acknowledge beats retraction; eret only honoured in SERVICE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (win_valid) state_d = ST_REQ;
      ST_REQ: begin
        if (int_ack) begin
          state_d = ST_SERVICE;
        end else if (!req_elig) begin
`ifdef IRQ_CTRL_NESTED_EN
          state_d = (|insvc_q) ? ST_SERVICE : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_SERVICE: begin
        if (eret) begin
`ifdef IRQ_CTRL_NESTED_EN
          state_d = (|(insvc_q & ~top_oh)) ? ST_SERVICE : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
`ifdef IRQ_CTRL_NESTED_EN
        else if (win_valid && (win_id < top_id)) begin
          state_d = ST_REQ;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: request id tracks the current winner while requesting
  always_comb begin
    int_req_d = (state_d == ST_REQ);
    int_id_d  = (state_d == ST_REQ) ? win_id : int_id_q;
    insvc_d   = insvc_q;
    ack_clr   = '0;
    if ((state_q == ST_REQ) && int_ack) begin
      insvc_d = insvc_q | id_oh;
      ack_clr = id_oh & EdgeM;
    end else if ((state_q == ST_SERVICE) && eret) begin
      insvc_d = insvc_q & ~top_oh;
    end
  end

  // Pending: edge lines latch rising edges (set beats clear), level lines mirror
  always_comb begin
    w1c    = (we && (addr == REG_PEND)) ? (wdata[NUM_IRQ-1:0] & EdgeM) : '0;
    pend_d = (EdgeM & ((sync2_q & ~sync3_q) | (pend_q & ~(w1c | ack_clr))))
           | (~EdgeM & sync2_q);
  end

  // Synchronisers, pending latch and software registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      gie_q   <= 1'b0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      pend_q  <= pend_d;
      if (we && (addr == REG_MASK)) mask_q <= wdata[NUM_IRQ-1:0];
      if (we && (addr == REG_CTRL)) gie_q  <= wdata[CTRL_GIE];
    end
  end

  // Register read mux; unused bits read zero
  always_comb begin
    rdata = '0;
    case (addr)
      REG_MASK: rdata[NUM_IRQ-1:0] = mask_q;
      REG_PEND: rdata[NUM_IRQ-1:0] = pend_q;
      REG_STAT: begin
        rdata[STAT_INSVC_LSB +: NUM_IRQ] = insvc_q;
        rdata[1:0]                       = state_q;
      end
      default:  rdata[CTRL_GIE] = gie_q;
    endcase
  end

  assign int_req = int_req_q;
  assign int_id  = int_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios then random traffic,
// every cycle compared against a behavioural model of the controller.
// Follows IRQ_CTRL_NESTED_EN the same way the design does.
module tb_irq_ctrl;

`ifdef IRQ_CTRL_NESTED_EN
  localparam bit NESTED = 1'b1;
`else
  localparam bit NESTED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  irq_in = '0;
  logic [1:0]  addr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        int_req;
  logic [2:0]  int_id;
  logic        int_ack = 1'b0;
  logic        eret = 1'b0;

  always #10 clk = ~clk;

  irq_ctrl #(.NUM_IRQ(6), .EDGE_MASK(6'b000011)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq_in  (irq_in),
    .addr    (addr),
    .we      (we),
    .wdata   (wdata),
    .rdata   (rdata),
    .int_req (int_req),
    .int_id  (int_id),
    .int_ack (int_ack),
    .eret    (eret)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: 0 idle, 1 requesting, 2 in service
  bit [5:0] edge_lines = 6'b000011;
  int       m_state;
  int       m_id;
  bit       m_req;
  bit       m_gie;
  bit [5:0] m_pend, m_mask, m_insvc;
  bit [5:0] samp[$];   // irq_in as seen at the last three clock edges, oldest first

  function automatic int lowest(bit [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return 7;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_id = 0; m_req = 0; m_gie = 0;
    m_pend = '0; m_mask = '0; m_insvc = '0;
    samp = '{6'h0, 6'h0, 6'h0};
  endtask

  task automatic model_edge();
    bit [5:0] lvl, rise, elig, clr;
    int w, t;
    lvl  = samp[1];
    rise = samp[1] & ~samp[0];
    elig = m_pend & m_mask & (m_gie ? 6'h3F : 6'h00);
    w    = lowest(elig);
    clr  = '0;
    case (m_state)
      0: if (w != 7) begin m_state = 1; m_id = w; end
      1: begin
        if (int_ack) begin
          m_state = 2;
          m_insvc[m_id] = 1'b1;
          clr[m_id] = edge_lines[m_id];
        end else if (!elig[m_id]) begin
          m_state = (NESTED && m_insvc != 0) ? 2 : 0;
        end else begin
          m_id = w;
        end
      end
      default: begin
        t = lowest(m_insvc);
        if (eret) begin
          m_insvc[t] = 1'b0;
          m_state = (NESTED && m_insvc != 0) ? 2 : 0;
        end else if (NESTED && w < t) begin
          m_state = 1; m_id = w;
        end
      end
    endcase
    if (we && addr == 2'd1) clr |= wdata[5:0] & edge_lines;
    for (int i = 0; i < 6; i++) begin
      if (edge_lines[i]) m_pend[i] = rise[i] | (m_pend[i] & ~clr[i]);
      else               m_pend[i] = lvl[i];
    end
    if (we && addr == 2'd0) m_mask = wdata[5:0];
    if (we && addr == 2'd3) m_gie  = wdata[0];
    m_req = (m_state == 1);
    samp.push_back(irq_in);
    void'(samp.pop_front());
  endtask

  task automatic check_all();
    logic [1:0] a_save;
    a_save = addr;
    chk("int_req", {31'b0, int_req}, {31'b0, m_req});
    if (m_req) chk("int_id", {29'b0, int_id}, 32'(m_id));
    addr = 2'd0; #1 chk("MASK", rdata, {26'b0, m_mask});
    addr = 2'd1; #1 chk("PENDING", rdata, {26'b0, m_pend});
    addr = 2'd2; #1 chk("STATUS", rdata, {18'b0, m_insvc, 6'b0, 2'(m_state)});
    addr = 2'd3; #1 chk("CTRL", rdata, {31'b0, m_gie});
    addr = a_save;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    we = 1'b0; int_ack = 1'b0; eret = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    step();
  endtask

  task automatic rd_chk(string tag, logic [1:0] a, logic [31:0] exp);
    addr = a;
    #1 chk(tag, rdata, exp);
  endtask

  task automatic wait_req(int max);
    for (int i = 0; i < max && int_req !== 1'b1; i++) step();
    chk("wait_req", {31'b0, int_req}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (m_state == 1) int_ack = 1'b1;
      else if (m_state == 2) eret = 1'b1;
      step();
    end
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_int_req", {31'b0, int_req}, 32'd0);
    check_all();
    irq_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Basic request on edge line 1
    wr(2'd0, 32'h3F);
    wr(2'd3, 32'h1);
    irq_in = 6'h02;
    step();                       // edge N
    step();                       // N+1
    irq_in = 6'h00;
    step();                       // N+2
    rd_chk("basic_pend", 2'd1, 32'h2);
    chk("basic_noreq_yet", {31'b0, int_req}, 32'd0);
    step();                       // N+3
    chk("basic_req", {31'b0, int_req}, 32'd1);
    chk("basic_id", {29'b0, int_id}, 32'd1);
    int_ack = 1'b1;
    step();
    chk("basic_ack_req", {31'b0, int_req}, 32'd0);
    rd_chk("basic_ack_pend", 2'd1, 32'h0);
    rd_chk("basic_ack_stat", 2'd2, 32'h202);
    eret = 1'b1;
    step();
    rd_chk("basic_eret_stat", 2'd2, 32'h0);

    // Priority replacement: level line 3 then edge line 0
    irq_in = 6'h08;
    wait_req(10);
    chk("prio_id3", {29'b0, int_id}, 32'd3);
    irq_in = 6'h09;
    idle(4);
    chk("prio_id0", {29'b0, int_id}, 32'd0);
    int_ack = 1'b1;
    step();
    irq_in = 6'h08;
    rd_chk("prio_pend3", 2'd1, 32'h8);
    eret = 1'b1;
    step();
    wait_req(5);
    chk("prio_after_eret", {29'b0, int_id}, 32'd3);
    int_ack = 1'b1;
    step();
    irq_in = 6'h00;
    idle(4);
    eret = 1'b1;
    step();
    idle(2);

    // Retract by masking the requested line, then ack in the write cycle
    irq_in = 6'h02;
    idle(2);
    irq_in = 6'h00;
    wait_req(10);
    wr(2'd0, 32'h3D);
    step();
    chk("retract_req", {31'b0, int_req}, 32'd0);
    rd_chk("retract_stat", 2'd2, 32'h0);
    wr(2'd0, 32'h3F);
    wait_req(5);
    addr = 2'd0; wdata = 32'h3D; we = 1'b1; int_ack = 1'b1;
    step();
    rd_chk("retract_ack_stat", 2'd2, 32'h202);
    eret = 1'b1;
    step();
    wr(2'd0, 32'h3F);
    idle(2);

    // W1C and a newly captured edge in the same cycle: set wins
    wr(2'd0, 32'h00);
    irq_in = 6'h01;
    idle(2);
    irq_in = 6'h00;
    idle(4);
    rd_chk("setclr_pre", 2'd1, 32'h1);
    irq_in = 6'h01;
    step();
    step();
    addr = 2'd1; wdata = 32'h1; we = 1'b1;
    step();
    rd_chk("set_beats_clr", 2'd1, 32'h1);
    irq_in = 6'h00;
    wr(2'd1, 32'h1);
    rd_chk("w1c_clears", 2'd1, 32'h0);
    wr(2'd0, 32'h3F);

    // Level line 4 acked then dropped; async reset while in service
    irq_in = 6'h10;
    wait_req(10);
    int_ack = 1'b1;
    step();
    irq_in = 6'h00;
    idle(3);
    rd_chk("level_drop", 2'd1, 32'h0);
    async_reset();
    idle(2);

    // Nesting: service line 2, then raise line 0
    wr(2'd0, 32'h3F);
    wr(2'd3, 32'h1);
    irq_in = 6'h04;
    wait_req(10);
    int_ack = 1'b1;
    step();
    irq_in = 6'h05;
    idle(5);
    if (NESTED) begin
      chk("nest_req", {31'b0, int_req}, 32'd1);
      chk("nest_id", {29'b0, int_id}, 32'd0);
      int_ack = 1'b1;
      step();
      rd_chk("nest_stat", 2'd2, 32'h502);
      eret = 1'b1;
      step();
      rd_chk("nest_eret1", 2'd2, 32'h402);
      eret = 1'b1;
      step();
      rd_chk("nest_eret2", 2'd2, 32'h0);
    end else begin
      chk("flat_noreq", {31'b0, int_req}, 32'd0);
      eret = 1'b1;
      step();
    end
    irq_in = 6'h00;
    drain();

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 6; b++)
        if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
      if ($urandom_range(0, 15) == 0) begin
        addr  = 2'($urandom_range(0, 3));
        wdata = $urandom;
        if (addr == 2'd3) wdata[0] = ($urandom_range(0, 7) != 0);
        if (addr == 2'd0 && $urandom_range(0, 1) == 1) wdata[5:0] = 6'h3F;
        we = 1'b1;
      end
      if (m_state == 1) int_ack = ($urandom_range(0, 2) == 0);
      else              int_ack = ($urandom_range(0, 29) == 0);
      if (m_state == 2) eret = ($urandom_range(0, 5) == 0);
      else              eret = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
